ext_unit_arbiter: RTL and testbench

// Shares one immediate-extension datapath (zero, sign, upper/LUI, branch-offset) between two

---
 rtl/ext_unit_arbiter.sv | 67 ++++++
 tb/tb_ext_unit_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ext_unit_arbiter.sv
// ext_unit_arbiter: round-robin shared immediate extender feeding a one-entry result buffer
module ext_unit_arbiter #(
   parameter int DEPTH    = 16,
   parameter int BR_SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [DEPTH-1:0] req_imm0,
   input  logic [DEPTH-1:0] req_imm1,
   input  logic [1:0]       req_mode0,
   input  logic [1:0]       req_mode1,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_id,
   output logic [31:0]      res_data
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state, state_nx;
   logic             rr_ptr, winner, grant, can_load;
   logic [DEPTH-1:0] imm;
   logic [1:0]       mode;
   logic [31:0]      sign_ext, ext;

   // arbitration, handshake and next-state; req_ready is forced low while reset is asserted
   always_comb begin
      can_load  = (state == EMPTY) | res_ready;
      winner    = &req_valid ? rr_ptr : req_valid[1];
      grant     = can_load & |req_valid;
      req_ready = (rst_n & grant) ? (winner ? 2'b10 : 2'b01) : 2'b00;
      state_nx  = grant ? FULL : (res_ready ? EMPTY : state);
   end

   // extension of the winning requester's immediate
   always_comb begin
      imm      = winner ? req_imm1 : req_imm0;
      mode     = winner ? req_mode1 : req_mode0;
      sign_ext = {{(32-DEPTH){imm[DEPTH-1]}}, imm};
      ext      = (mode == 2'b00) ? {{(32-DEPTH){1'b0}}, imm} :
                 (mode == 2'b01) ? sign_ext :
                 (mode == 2'b10) ? {imm, {(32-DEPTH){1'b0}}} :
                                   sign_ext << BR_SHIFT;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= EMPTY;
      else        state <= state_nx;

   // result buffer and round-robin pointer, updated only on a granted transfer
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         res_id   <= 1'b0;
         res_data <= 32'h0;
         rr_ptr   <= 1'b0;
      end else if (grant) begin
         res_id   <= winner;
         res_data <= ext;
         rr_ptr   <= ~winner;
      end

   assign res_valid = (state == FULL);

endmodule

// File: tb/tb_ext_unit_arbiter.sv
// tb_ext_unit_arbiter: scoreboard bench with a queue-based reference model
module tb_ext_unit_arbiter;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [1:0]  req_valid = 2'b00, req_ready;
   logic [15:0] req_imm0 = '0, req_imm1 = '0;
   logic [1:0]  req_mode0 = '0, req_mode1 = '0;
   logic        res_valid, res_ready = 1'b0, res_id;
   logic [31:0] res_data;

   int total = 0, bad = 0;
   logic [32:0] sb[$];
   logic        rr = 1'b0;
   int          wait_cnt[2] = '{0, 0};

   ext_unit_arbiter #(.DEPTH(16), .BR_SHIFT(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_imm0(req_imm0), .req_imm1(req_imm1), .req_mode0(req_mode0), .req_mode1(req_mode1),
      .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_ext(input logic [15:0] a, input logic [1:0] m);
      int s;
      s = $signed(a);
      case (m)
         2'd0: return 32'(a);
         2'd1: return 32'(s);
         2'd2: return 32'(a) * 32'd65536;
         default: return 32'(s) * 32'd4;
      endcase
   endfunction

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // one cycle: drive, check ready against the model, then account the transfer at the edge
   task automatic step(input logic [1:0] v, input logic [15:0] a0, input logic [1:0] m0,
                       input logic [15:0] a1, input logic [1:0] m1, input logic rdy,
                       output logic [1:0] got);
      logic       w;
      logic [1:0] er;
      req_valid = v; req_imm0 = a0; req_mode0 = m0; req_imm1 = a1; req_mode1 = m1; res_ready = rdy;
      #2;
      w  = (v == 2'b11) ? rr : v[1];
      er = ((sb.size() == 0 || rdy) && v != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;
      check("req_ready", {31'b0, req_ready}, {31'b0, er});
      got = er;
      @(posedge clk);
      if (er != 2'b00) begin
         sb.push_back({w, w ? ref_ext(a1, m1) : ref_ext(a0, m0)});
         check("starve", 33'(wait_cnt[w] <= 1), 33'd1);
         wait_cnt[w] = 0;
         if (v[~w]) wait_cnt[~w]++;
         rr = ~w;
      end
      #1;
   endtask

   // monitor: whatever the DUT presents must match the head of the scoreboard
   always @(negedge clk) if (rst_n) begin
      check("res_valid", {32'b0, res_valid}, {32'b0, sb.size() != 0});
      if (res_valid && sb.size() != 0) begin
         check("result", {res_id, res_data}, sb[0]);
         if (res_ready) void'(sb.pop_front());
      end
   end

   initial begin
      logic [1:0]  g;
      logic [1:0]  pv;
      logic [15:0] pa[2];
      logic [1:0]  pm[2];
      logic [31:0] mode_exp[4];
      mode_exp = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
      req_valid = 2'b11;
      #12;
      check("rst_valid", {32'b0, res_valid}, 33'd0);
      check("rst_data", {res_id, res_data}, 33'd0);
      check("rst_ready", {31'b0, req_ready}, 33'd0);
      rst_n = 1'b1;
      req_valid = 2'b00;
      @(posedge clk); #1;
      for (int m = 0; m < 4; m++) begin
         step(2'b01, 16'h8001, 2'(m), 16'h0, 2'd0, 1'b1, g);
         #3;
         check("mode", {res_id, res_data}, {1'b0, mode_exp[m]});
         #1;
      end
      step(2'b00, 0, 0, 0, 0, 1'b1, g);
      for (int i = 0; i < 4; i++) step(2'b11, 16'h1234 + 16'(i), 2'd1, 16'hF00F, 2'd3, 1'b1, g);
      step(2'b00, 0, 0, 0, 0, 1'b1, g);
      step(2'b10, 16'h0, 2'd0, 16'h0010, 2'd1, 1'b0, g);
      for (int i = 0; i < 3; i++) begin
         step(2'b01, 16'h7FFF, 2'd2, 16'h0, 2'd0, 1'b0, g);
         #3;
         check("hold", {res_id, res_data}, {1'b1, 32'h00000010});
         #1;
      end
      step(2'b01, 16'h7FFF, 2'd2, 16'h0, 2'd0, 1'b1, g);
      check("reload", {31'b0, g}, 33'd1);
      step(2'b00, 0, 0, 0, 0, 1'b1, g);
      step(2'b00, 0, 0, 0, 0, 1'b1, g);
      step(2'b11, 16'hAAAA, 2'd3, 16'h5555, 2'd2, 1'b1, g);
      step(2'b11, 16'hAAAA, 2'd3, 16'h5555, 2'd2, 1'b0, g);
      req_valid = 2'b11;
      #1 rst_n = 1'b0;
      #1;
      check("arst_valid", {32'b0, res_valid}, 33'd0);
      check("arst_data", {res_id, res_data}, 33'd0);
      check("arst_ready", {31'b0, req_ready}, 33'd0);
      sb.delete();
      rr = 1'b0;
      wait_cnt = '{0, 0};
      #1 rst_n = 1'b1;
      pv = 2'b00;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < 2; i++)
            if (!pv[i] && $urandom_range(1, 0) == 1) begin
               pv[i] = 1'b1;
               pa[i] = 16'($urandom);
               pm[i] = 2'($urandom);
            end
         step(pv, pa[0], pm[0], pa[1], pm[1], $urandom_range(3, 0) != 0, g);
         pv = pv & ~g;
      end
      for (int i = 0; i < 2; i++) step(2'b00, 0, 0, 0, 0, 1'b1, g);
      check("drained", 33'(sb.size()), 33'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
